// File: rtl/uv_edge_buffer.sv
// Chroma neighbour-edge store: captures reconstructed 8x8 U/V blocks row by row,
// keeps each column's bottom row in a top-line RAM and the last block's right column.
module uv_edge_buffer #(
   parameter int BIT_WIDTH  = 8,
   parameter int BLOCK_SIZE = 8,
   parameter int BLOCK_NUM  = 10,
   parameter int ADDR_W     = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_start,
   input  logic [BLOCK_NUM-1:0]            wr_x,
   input  logic [BLOCK_NUM-1:0]            wr_y,
   input  logic                            rec_valid,
   input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] rec_u,
   input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] rec_v,
   output logic                            wr_done,
   input  logic                            rd_start,
   input  logic [BLOCK_NUM-1:0]            rd_x,
   input  logic [BLOCK_NUM-1:0]            rd_y,
   output logic [BIT_WIDTH*BLOCK_SIZE-1:0] top_u,
   output logic [BIT_WIDTH*BLOCK_SIZE-1:0] top_v,
   output logic [BIT_WIDTH*BLOCK_SIZE-1:0] left_u,
   output logic [BIT_WIDTH*BLOCK_SIZE-1:0] left_v,
   output logic                            rd_done,
   output logic                            busy
);

   localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;
   localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [CNT_W-1:0]     LAST_ROW  = CNT_W'(BLOCK_SIZE - 1);
   localparam logic [BIT_WIDTH-1:0] TOP_FILL  = BIT_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
   localparam logic [BIT_WIDTH-1:0] LEFT_FILL = BIT_WIDTH'((1 << (BIT_WIDTH - 1)) + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      RD_MEM = 2'd2,
      RD_OUT = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    row_cnt_reg;
   logic [ADDR_W-1:0]   wr_addr_reg;
   logic [ADDR_W-1:0]   rd_addr_reg;
   logic                rd_top_edge_reg;
   logic                rd_left_edge_reg;
   logic                wr_done_reg;
   logic                rd_done_reg;
   logic [ROW_W-1:0]    top_u_reg, top_v_reg, left_u_reg, left_v_reg;
   logic [2*ROW_W-1:0]  ram_rd_reg;
   logic [2*ROW_W-1:0]  ram_mem [2**ADDR_W];

   logic [BIT_WIDTH-1:0] col_u_reg [BLOCK_SIZE];
   logic [BIT_WIDTH-1:0] col_v_reg [BLOCK_SIZE];
   logic [ROW_W-1:0]     col_u_vec, col_v_vec;

   logic rd_accept, wr_accept, row_accept, last_row, ram_rd_en, out_load, ram_we;

   // Only the column address matters for storage; the row coordinate is informational.
   logic unused_wr_coord;
   assign unused_wr_coord = ^{wr_y, wr_x};

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      rd_accept  = 1'b0;
      wr_accept  = 1'b0;
      row_accept = 1'b0;
      last_row   = 1'b0;
      ram_rd_en  = 1'b0;
      out_load   = 1'b0;
      case (state_reg)
         IDLE: begin
            // A simultaneous write request loses to the read and is dropped.
            if (rd_start) begin
               rd_accept  = 1'b1;
               state_next = RD_MEM;
            end else if (wr_start) begin
               wr_accept  = 1'b1;
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (rec_valid) begin
               row_accept = 1'b1;
               if (row_cnt_reg == LAST_ROW) begin
                  last_row   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         RD_MEM: begin
            ram_rd_en  = 1'b1;
            state_next = RD_OUT;
         end
         RD_OUT: begin
            out_load   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A reset landing on the final row must not commit the block.
   assign ram_we = last_row & ~rst;

   always_ff @(posedge clk) begin
      if (ram_we) ram_mem[wr_addr_reg] <= {rec_v, rec_u};
      if (ram_rd_en) ram_rd_reg <= ram_mem[rd_addr_reg];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_reg      <= '0;
         wr_addr_reg      <= '0;
         rd_addr_reg      <= '0;
         rd_top_edge_reg  <= 1'b0;
         rd_left_edge_reg <= 1'b0;
         wr_done_reg      <= 1'b0;
         rd_done_reg      <= 1'b0;
      end else begin
         wr_done_reg <= last_row;
         rd_done_reg <= out_load;
         if (wr_accept) begin
            wr_addr_reg <= wr_x[ADDR_W-1:0];
            row_cnt_reg <= '0;
         end else if (row_accept) begin
            row_cnt_reg <= last_row ? '0 : row_cnt_reg + 1'b1;
         end
         if (rd_accept) begin
            rd_addr_reg      <= rd_x[ADDR_W-1:0];
            rd_top_edge_reg  <= (rd_y == '0);
            rd_left_edge_reg <= (rd_x == '0);
         end
      end
   end

   // Right-most sample of each accepted row forms the left neighbour column.
   generate
      for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_left_col
         always_ff @(posedge clk) begin
            if (rst) begin
               col_u_reg[gi] <= '0;
               col_v_reg[gi] <= '0;
            end else if (row_accept && row_cnt_reg == CNT_W'(gi)) begin
               col_u_reg[gi] <= rec_u[ROW_W-1 -: BIT_WIDTH];
               col_v_reg[gi] <= rec_v[ROW_W-1 -: BIT_WIDTH];
            end
         end
         assign col_u_vec[gi*BIT_WIDTH +: BIT_WIDTH] = col_u_reg[gi];
         assign col_v_vec[gi*BIT_WIDTH +: BIT_WIDTH] = col_v_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         top_u_reg  <= '0;
         top_v_reg  <= '0;
         left_u_reg <= '0;
         left_v_reg <= '0;
      end else if (out_load) begin
         top_u_reg  <= rd_top_edge_reg  ? {BLOCK_SIZE{TOP_FILL}}  : ram_rd_reg[ROW_W-1:0];
         top_v_reg  <= rd_top_edge_reg  ? {BLOCK_SIZE{TOP_FILL}}  : ram_rd_reg[2*ROW_W-1:ROW_W];
         left_u_reg <= rd_left_edge_reg ? {BLOCK_SIZE{LEFT_FILL}} : col_u_vec;
         left_v_reg <= rd_left_edge_reg ? {BLOCK_SIZE{LEFT_FILL}} : col_v_vec;
      end
   end

   assign top_u   = top_u_reg;
   assign top_v   = top_v_reg;
   assign left_u  = left_u_reg;
   assign left_v  = left_v_reg;
   assign wr_done = wr_done_reg;
   assign rd_done = rd_done_reg;
   assign busy    = (state_reg != IDLE);

endmodule
